// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl
//   Memory-side responder for a two-core dcache/icache system. Arbitrates
//   both dcaches and both icaches onto one RAM port, runs the snoop handshake
//   towards the non-requesting dcache and performs cache-to-cache transfers
//   while writing the dirty copy back to RAM.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   dREN, dWEN, daddr, dstore dcache read/write-back requests, address, data
//   cctrans, ccwrite          coherence miss marker / exclusive intent or snoop hit
//   dwait, dload              dcache wait (low on the completing cycle), read data
//   ccwait, ccinv, ccsnoopaddr snoop strobe, invalidate, snoop address
//   iREN, iaddr, iwait, iload icache request, address, wait, data
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate   RAM port
//
// state  | meaning
// IDLE   | no transaction, wait for any request
// ARB    | pick dcache (round robin on dlast) over icache (round robin on ilast)
// SNOOP  | one cycle: snoop the other dcache, sample its ccwrite reply
// C2C1/2 | word 0/1 supplied by the other dcache, also written to RAM
// MEM1/2 | word 0/1 read from RAM
// WB1/2  | word 0/1 write-back to RAM
// IFETCH | single instruction word read from RAM

module coherence_bus_ctrl #(
  parameter int          CPUS       = 2,
  parameter logic [1:0]  RAM_ACCESS = 2'b10
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS-1:0][31:0]     daddr,
  input  logic [CPUS-1:0][31:0]     dstore,
  input  logic [CPUS-1:0]           cctrans,
  input  logic [CPUS-1:0]           ccwrite,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS-1:0][31:0]     dload,
  output logic [CPUS-1:0]           ccwait,
  output logic [CPUS-1:0]           ccinv,
  output logic [CPUS-1:0][31:0]     ccsnoopaddr,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0][31:0]     iaddr,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0][31:0]     iload,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  logic [1:0]                ramstate
);

  typedef enum logic [3:0] {
    IDLE, ARB, SNOOP, C2C1, C2C2, MEM1, MEM2, WB1, WB2, IFETCH
  } state_t;

  state_t state, state_nxt;
  logic   req, req_nxt;
  logic   dlast, dlast_nxt;
  logic   ilast, ilast_nxt;

  logic [CPUS-1:0] dreq;
  logic            dsel, isel, oth, access, d_live;

  assign dreq   = dREN | dWEN;
  // With both cores asking, the one not served last wins; otherwise the only requester.
  assign dsel   = (&dreq) ? ~dlast : dreq[1];
  assign isel   = (&iREN) ? ~ilast : iREN[1];
  assign oth    = ~req;
  assign access = (ramstate == RAM_ACCESS);
  assign d_live = dREN[req] | dWEN[req];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= 1'b0;
      dlast <= 1'b0;
      ilast <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
      dlast <= dlast_nxt;
      ilast <= ilast_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_nxt     = req;
    dlast_nxt   = dlast;
    ilast_nxt   = ilast;
    dwait       = '1;
    iwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    dload       = '0;
    iload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      IDLE: begin
        if ((|dreq) || (|iREN)) state_nxt = ARB;
      end

      ARB: begin
        if (|dreq) begin
          req_nxt   = dsel;
          dlast_nxt = dsel;
          state_nxt = dWEN[dsel] ? WB1 : SNOOP;
        end else if (|iREN) begin
          req_nxt   = isel;
          ilast_nxt = isel;
          state_nxt = IFETCH;
        end else begin
          state_nxt = IDLE;
        end
      end

      WB1, WB2: begin
        if (!d_live) begin
          state_nxt = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[req];
          ramstore = dstore[req];
          if (access) begin
            dwait[req] = 1'b0;
            state_nxt  = (state == WB1) ? WB2 : IDLE;
          end
        end
      end

      SNOOP: begin
        if (!d_live) begin
          state_nxt = IDLE;
        end else begin
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = daddr[req];
          ccinv[oth]       = ccwrite[req] & cctrans[req];
          state_nxt        = ccwrite[oth] ? C2C1 : MEM1;
        end
      end

      C2C1, C2C2: begin
        if (!d_live) begin
          state_nxt = IDLE;
        end else begin
          // Snoop address follows the requester so the snooper supplies the matching word.
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = daddr[req];
          ccinv[oth]       = ccwrite[req] & cctrans[req];
          dload[req]       = dstore[oth];
          ramWEN           = 1'b1;
          ramaddr          = daddr[req];
          ramstore         = dstore[oth];
          if (access) begin
            dwait[req] = 1'b0;
            state_nxt  = (state == C2C1) ? C2C2 : IDLE;
          end
        end
      end

      MEM1, MEM2: begin
        if (!d_live) begin
          state_nxt = IDLE;
        end else begin
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = daddr[req];
          ccinv[oth]       = ccwrite[req] & cctrans[req];
          ramREN           = 1'b1;
          ramaddr          = daddr[req];
          dload[req]       = ramload;
          if (access) begin
            dwait[req] = 1'b0;
            state_nxt  = (state == MEM1) ? MEM2 : IDLE;
          end
        end
      end

      IFETCH: begin
        if (!iREN[req]) begin
          state_nxt = IDLE;
        end else begin
          ramREN     = 1'b1;
          ramaddr    = iaddr[req];
          iload[req] = ramload;
          if (access) begin
            iwait[req] = 1'b0;
            state_nxt  = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite, iREN, ramstate;
  logic [1:0][31:0] daddr, dstore, iaddr;
  logic [31:0]      ramload;
  logic [1:0]       dwait, ccwait, ccinv, iwait;
  logic [1:0][31:0] dload, ccsnoopaddr, iload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    logic [1:0]       dren, dwen, cctrans, ccwrite, iren, rs;
    logic [1:0][31:0] da, ds, ia;
    logic [31:0]      rl;
    logic [1:0]       e_dwait, e_iwait, e_ccwait, e_ccinv;
    logic             e_ren, e_wen;
    logic [31:0]      e_raddr, e_rstore;
    logic [1:0][31:0] e_dl, e_il, e_sa;
  } vec_t;

  vec_t v;
  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic ed();
    v.e_dwait = 2'b11; v.e_iwait = 2'b11; v.e_ccwait = 2'b00; v.e_ccinv = 2'b00;
    v.e_ren = 1'b0; v.e_wen = 1'b0; v.e_raddr = '0; v.e_rstore = '0;
    v.e_dl = '0; v.e_il = '0; v.e_sa = '0;
  endtask

  task automatic snp(input int c, input logic [31:0] a, input logic inv);
    v.e_ccwait[c] = 1'b1; v.e_sa[c] = a; v.e_ccinv[c] = inv;
  endtask

  task automatic rd(input int c, input logic [31:0] a, input logic [31:0] d);
    v.e_ren = 1'b1; v.e_raddr = a; v.e_dl[c] = d; v.e_dwait[c] = 1'b0;
  endtask

  task automatic wb(input int c, input logic [31:0] a, input logic [31:0] d);
    v.e_wen = 1'b1; v.e_raddr = a; v.e_rstore = d; v.e_dwait[c] = 1'b0;
  endtask

  task automatic c2c(input int c, input logic [31:0] a, input logic [31:0] d);
    v.e_wen = 1'b1; v.e_raddr = a; v.e_rstore = d; v.e_dl[c] = d; v.e_dwait[c] = 1'b0;
  endtask

  task automatic push();
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t x);
    dREN = x.dren; dWEN = x.dwen; cctrans = x.cctrans; ccwrite = x.ccwrite;
    iREN = x.iren; ramstate = x.rs; daddr = x.da; dstore = x.ds; iaddr = x.ia;
    ramload = x.rl;
  endtask

  task automatic check_vec(input int i, input vec_t x);
    chk("dwait",    i, 32'(dwait),   32'(x.e_dwait));
    chk("iwait",    i, 32'(iwait),   32'(x.e_iwait));
    chk("ccwait",   i, 32'(ccwait),  32'(x.e_ccwait));
    chk("ccinv",    i, 32'(ccinv),   32'(x.e_ccinv));
    chk("ramREN",   i, 32'(ramREN),  32'(x.e_ren));
    chk("ramWEN",   i, 32'(ramWEN),  32'(x.e_wen));
    chk("ramaddr",  i, ramaddr,      x.e_raddr);
    chk("ramstore", i, ramstore,     x.e_rstore);
    chk("dload0",   i, dload[0],     x.e_dl[0]);
    chk("dload1",   i, dload[1],     x.e_dl[1]);
    chk("iload0",   i, iload[0],     x.e_il[0]);
    chk("iload1",   i, iload[1],     x.e_il[1]);
    chk("snoop0",   i, ccsnoopaddr[0], x.e_sa[0]);
    chk("snoop1",   i, ccsnoopaddr[1], x.e_sa[1]);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; iREN = '0;
    ramstate = 2'b10; daddr = '0; dstore = '0; iaddr = '0; ramload = '0;
  endtask

  initial begin
    // ---------------- vector table ----------------
    v = '{default: '0};
    v.rs = 2'b10;

    // core0 read miss from RAM
    v.dren = 2'b01; v.da[0] = 32'h100;
    ed(); push();
    ed(); push();
    ed(); snp(1, 32'h100, 1'b0); push();
    v.rl = 32'hDEAD0000; ed(); snp(1, 32'h100, 1'b0); rd(0, 32'h100, 32'hDEAD0000); push();
    v.da[0] = 32'h104; v.rl = 32'hDEAD0004;
    ed(); snp(1, 32'h104, 1'b0); rd(0, 32'h104, 32'hDEAD0004); push();
    v.dren = 2'b00; ed(); push();

    // both cores read, dlast=0: core1 first, then core0 even though core1 asks again
    v.dren = 2'b11; v.da[0] = 32'h400; v.da[1] = 32'h500; v.rl = '0;
    ed(); push();
    ed(); push();
    ed(); snp(0, 32'h500, 1'b0); push();
    v.rl = 32'hA1; ed(); snp(0, 32'h500, 1'b0); rd(1, 32'h500, 32'hA1); push();
    v.da[1] = 32'h504; v.rl = 32'hA2; ed(); snp(0, 32'h504, 1'b0); rd(1, 32'h504, 32'hA2); push();
    v.da[1] = 32'h540; ed(); push();
    ed(); push();
    ed(); snp(1, 32'h400, 1'b0); push();
    v.rl = 32'hB1; ed(); snp(1, 32'h400, 1'b0); rd(0, 32'h400, 32'hB1); push();
    v.da[0] = 32'h404; v.rl = 32'hB2; ed(); snp(1, 32'h404, 1'b0); rd(0, 32'h404, 32'hB2); push();
    v.dren = 2'b00; ed(); push();

    // core0 write-back beats pending core1 ifetch
    v.dwen = 2'b01; v.iren = 2'b10; v.da[0] = 32'h200; v.ds[0] = 32'h5A5A0000; v.ia[1] = 32'h600;
    ed(); push();
    ed(); push();
    ed(); wb(0, 32'h200, 32'h5A5A0000); push();
    v.da[0] = 32'h204; v.ds[0] = 32'h5A5A0004; ed(); wb(0, 32'h204, 32'h5A5A0004); push();
    v.dwen = 2'b00; ed(); push();
    ed(); push();
    v.rl = 32'h13; ed(); v.e_ren = 1'b1; v.e_raddr = 32'h600; v.e_il[1] = 32'h13; v.e_iwait = 2'b01; push();
    v.iren = 2'b00; ed(); push();

    // core1 write miss, core0 supplies dirty copy
    v.dren = 2'b10; v.cctrans = 2'b10; v.ccwrite = 2'b11; v.da[1] = 32'h300;
    v.ds[0] = 32'hCAFEBABE; v.rl = 32'hFFFFFFFF;
    ed(); push();
    ed(); push();
    ed(); snp(0, 32'h300, 1'b1); push();
    ed(); snp(0, 32'h300, 1'b1); c2c(1, 32'h300, 32'hCAFEBABE); push();
    v.da[1] = 32'h304; v.ds[0] = 32'hCAFEBAB4;
    ed(); snp(0, 32'h304, 1'b1); c2c(1, 32'h304, 32'hCAFEBAB4); push();
    v.dren = 2'b00; v.cctrans = 2'b00; v.ccwrite = 2'b00; ed(); push();

    // request dropped while MEM1 is stalled: no strobe, back to IDLE
    v.dren = 2'b01; v.da[0] = 32'h700; v.rl = 32'h77;
    ed(); push();
    ed(); push();
    ed(); snp(1, 32'h700, 1'b0); push();
    v.rs = 2'b01; ed(); snp(1, 32'h700, 1'b0); v.e_ren = 1'b1; v.e_raddr = 32'h700; v.e_dl[0] = 32'h77; push();
    v.dren = 2'b00; ed(); push();
    v.rs = 2'b10; ed(); push();

    // ---------------- reset ----------------
    nRST = 1'b0;
    idle_inputs();
    step();
    v = '{default: '0}; ed();
    check_vec(-1, v);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge CLK);
      check_vec(i, tbl[i]);
      step();
    end

    // ---------------- RAM busy for 3 cycles in MEM1 ----------------
    idle_inputs();
    dREN = 2'b01; daddr[0] = 32'h800; ramload = 32'h88;
    step(); step(); step();
    ramstate = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("busy_dwait",  k, 32'(dwait),  32'h3);
      chk("busy_ramREN", k, 32'(ramREN), 32'h1);
      chk("busy_addr",   k, ramaddr,     32'h800);
      step();
    end
    ramstate = 2'b10;
    @(negedge CLK);
    chk("busy_go_dwait", 0, 32'(dwait), 32'h2);
    chk("busy_go_dload", 0, dload[0],   32'h88);
    step();
    daddr[0] = 32'h804; ramload = 32'h8C;
    @(negedge CLK);
    chk("busy_mem2_addr",  0, ramaddr,     32'h804);
    chk("busy_mem2_dwait", 0, 32'(dwait),  32'h2);
    chk("busy_mem2_dload", 0, dload[0],    32'h8C);
    step();
    dREN = 2'b00;
    step();

    // ---------------- reset asserted during C2C2 ----------------
    dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b11; daddr[1] = 32'h900; dstore[0] = 32'h99;
    step(); step(); step(); step();
    daddr[1] = 32'h904;
    #1;
    chk("c2c2_ramWEN", 0, 32'(ramWEN), 32'h1);
    chk("c2c2_ccwait", 0, 32'(ccwait), 32'h1);
    nRST = 1'b0;
    #1;
    chk("rst_ccwait", 0, 32'(ccwait), 32'h0);
    chk("rst_ccinv",  0, 32'(ccinv),  32'h0);
    chk("rst_dwait",  0, 32'(dwait),  32'h3);
    chk("rst_ramWEN", 0, 32'(ramWEN), 32'h0);
    chk("rst_dload1", 0, dload[1],    32'h0);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    @(negedge CLK);
    chk("post_rst_dwait",  0, 32'(dwait),  32'h3);
    chk("post_rst_ramWEN", 0, 32'(ramWEN), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Bus/memory-side responder for the two-core dcache/icache system. It is the far end of the caches_if protocol that the dcaches and icaches initiate.
- Arbitrates two dcaches and two icaches onto one RAM port.
- Drives the snoop handshake (ccwait/ccinv/ccsnoopaddr) to the non-requesting dcache.
- Performs cache-to-cache transfers with concurrent write-back to RAM. Each dcache block is two words; each icache fetch is one word.

Parameters:
- CPUS, 2, number of cores. Fixed at 2; the snoop target is always the other core.
- RAM_ACCESS, 2'b10, ramstate encoding for completed access. FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dREN  in  2  per-core dcache read request.
- dWEN  in  2  per-core dcache write-back request.
- daddr  in  2x32  per-core dcache word address.
- dstore  in  2x32  write data from the requester, or snoop reply data from the snooper.
- cctrans  in  2  requester marks a coherence (miss) transaction.
- ccwrite  in  2  requester: exclusive intent (write miss). Snooper: valid copy present, data on dstore.
- dwait  out  2  per-core dcache wait. Low for exactly the completing cycle of each word.
- dload  out  2x32  per-core read data.
- ccwait  out  2  snoop active on that core.
- ccinv  out  2  invalidate snooped line.
- ccsnoopaddr  out  2x32  snoop address.
- iREN  in  2  per-core icache read request.
- iaddr  in  2x32  per-core icache address.
- iwait  out  2  per-core icache wait.
- iload  out  2x32  per-core instruction data.
- ramREN  out  1  RAM read.
- ramWEN  out  1  RAM write.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status.

Behaviour:
- Reset (async, any state): state=IDLE, req=0, dlast=0, ilast=0. Outputs: dwait=2'b11, iwait=2'b11, ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0, iload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0. Outputs are combinational from state, with these as defaults in every state.
- State machine states: IDLE, ARB, SNOOP, C2C1, C2C2, MEM1, MEM2, WB1, WB2, IFETCH.
- IDLE -> ARB when any dREN, dWEN or iREN is high; otherwise stay in IDLE.
- ARB, dcache selection:
  - Dcache requests (dREN|dWEN) beat icache requests.
  - Between two dcache requesters, grant the core != dlast. Latch req and set dlast=req.
  - dWEN[req] -> WB1. dREN[req] -> SNOOP.
- ARB, icache selection (no dcache request): grant iREN with the same round-robin on ilast, latch req, go to IFETCH. No request left -> IDLE.
- WB1 / WB2:
  - Drive ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req].
  - On ramstate==ACCESS: dwait[req]=0 that cycle, advance WB1->WB2->IDLE.
- SNOOP (one cycle):
  - Drive ccwait[~req]=1, ccsnoopaddr[~req]=daddr[req], ccinv[~req]=ccwrite[req]&cctrans[req].
  - Sample ccwrite[~req]: 1 -> C2C1, else -> MEM1.
  - No RAM access and no dwait release in this cycle.
- C2C1 / C2C2:
  - Keep the ccwait/ccsnoopaddr/ccinv drive (snoop address tracks the requester's current word).
  - Drive dload[req]=dstore[~req], ramWEN=1, ramaddr=daddr[req], ramstore=dstore[~req] (memory updated with the dirty copy).
  - On ACCESS: dwait[req]=0, advance C2C1->C2C2->IDLE.
- MEM1 / MEM2:
  - Keep the snoop drive.
  - Drive ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - On ACCESS: dwait[req]=0, advance MEM1->MEM2->IDLE.
- IFETCH:
  - Drive ramREN=1, ramaddr=iaddr[req], iload[req]=ramload.
  - On ACCESS: iwait[req]=0, go to IDLE.
- Stalls: ramstate BUSY, FREE or ERROR holds the current state with wait kept high. No timeout.
- Request dropped mid-transaction: if dREN[req]|dWEN[req] (or iREN[req] in IFETCH) is low in any non-IDLE, non-ARB state, go to IDLE next cycle. No wait is released and no RAM strobe is issued that cycle.
- The non-granted core always sees dwait=1 and iwait=1.
- Minimum latency with ramstate=ACCESS immediately:
  - Dcache read: 2 words in 5 cycles from request (IDLE, ARB, SNOOP, MEM1, MEM2).
  - Write-back: 4 cycles.
  - Ifetch: 3 cycles.

Test Plan:
- Core0 dREN, daddr=0x100, ramload=0xDEAD0000 then 0xDEAD0004, ACCESS each cycle -> ccwait[1] high for SNOOP, MEM1, MEM2; dwait[0] low in MEM1 and in MEM2; dload[0] shows those values; ccinv[1]=0.
- Core1 dREN with cctrans=1, ccwrite=1; core0 snoop replies ccwrite[0]=1, dstore=0xCAFEBABE -> ccinv[0]=1; state C2C1; ramWEN=1, ramstore=0xCAFEBABE, dload[1]=0xCAFEBABE.
- Both cores dREN in the same cycle, dlast=0 -> core1 served first, then core0. dlast toggles 1 then 0.
- dWEN[0] plus iREN[1] pending -> WB1/WB2 complete (ramaddr 0x200, 0x204) before IFETCH. iwait[1] stays high until the IFETCH ACCESS cycle.
- ramstate=BUSY for 3 cycles during MEM1 -> state held, dwait[req]=1, ramREN=1 held. Advance on the 4th cycle (ACCESS).
- Assert nRST low during C2C2 -> same cycle: ccwait=0, dwait=2'b11, ramWEN=0, state IDLE.
